// File: rtl/memory_access_unit_if.sv
// Data-memory bus between the memory access unit (master) and data memory (slave).
// Handshake: a request transfers on a clock edge where o_dmem_valid and i_dmem_ready are
// both high; while o_dmem_valid is high, addr/we/wstrb/wdata stay stable until accepted.
// A load response is a single cycle with i_dmem_rvalid high carrying i_dmem_rdata; it is
// only honoured while the master is waiting for it.
interface memory_access_unit_if #(
    parameter int DATA_SIZE = 32
);
    logic                   o_dmem_valid;
    logic                   i_dmem_ready;
    logic [DATA_SIZE-1:0]   o_dmem_addr;
    logic                   o_dmem_we;
    logic [DATA_SIZE/8-1:0] o_dmem_wstrb;
    logic [DATA_SIZE-1:0]   o_dmem_wdata;
    logic                   i_dmem_rvalid;
    logic [DATA_SIZE-1:0]   i_dmem_rdata;

    modport master (
        output o_dmem_valid, o_dmem_addr, o_dmem_we, o_dmem_wstrb, o_dmem_wdata,
        input  i_dmem_ready, i_dmem_rvalid, i_dmem_rdata
    );

    modport slave (
        input  o_dmem_valid, o_dmem_addr, o_dmem_we, o_dmem_wstrb, o_dmem_wdata,
        output i_dmem_ready, i_dmem_rvalid, i_dmem_rdata
    );
endinterface

// File: rtl/memory_access_unit.sv
// Memory access pipeline stage: registers execute results, runs data-memory loads/stores,
// aligns store lanes, extends load data and stalls upstream while an access is in flight.
package memory_access_unit_pkg;
    typedef enum logic [2:0] {LD_LB = 3'd0, LD_LH = 3'd1, LD_LW = 3'd2, LD_LBU = 3'd3, LD_LHU = 3'd4} t_ldop;
    typedef enum logic [1:0] {ST_SB = 2'd0, ST_SH = 2'd1, ST_SW = 2'd2} t_sop;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} t_state;
endpackage

module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int DATA_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 i_aclk,
    input  logic                 i_areset_n,
    input  logic                 i_en,
    input  logic [DATA_SIZE-1:0] i_exe_calc,
    input  logic [DATA_SIZE-1:0] i_exe_wdata,
    input  logic                 i_cu_regwrite,
    input  logic                 i_cu_memwrite,
    input  logic                 i_cu_memaccess,
    input  logic [1:0]           i_cu_memtoreg,
    input  t_ldop                i_ldop,
    input  t_sop                 i_sop,
    input  logic [4:0]           i_rdest,
    input  logic [DATA_SIZE-1:0] i_pcplus4,
    output logic                 o_stall,
    output logic [DATA_SIZE-1:0] o_ma_op,
    output logic [DATA_SIZE-1:0] o_rdata,
    output logic [4:0]           o_rdest,
    output logic [1:0]           o_cu_memtoreg,
    output logic [DATA_SIZE-1:0] o_pcplus4,
    output logic                 o_cu_regwrite,
    output logic                 o_misaligned,
    output logic                 o_bus_error,
    output logic [1:0]           o_state,
    memory_access_unit_if.master dmem
);
    // Counter only needs to reach TIMEOUT_CYCLES-1; the abort fires on that cycle.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    t_state               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_regwrite, r_memwrite, r_memaccess, r_bus_error;
    logic [DATA_SIZE-1:0] r_ldword;
    logic [DATA_SIZE-1:0] r_calc, r_wdata, r_pcplus4;
    logic [4:0]           r_rdest;
    logic [1:0]           r_memtoreg;
    t_ldop                r_ldop;
    t_sop                 r_sop;

    logic                 w_stall, w_timeout, w_in_misaligned, w_misaligned;
    logic [3:0]           w_wstrb;
    logic [DATA_SIZE-1:0] w_wdata;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;

    function automatic logic f_misaligned(input logic [1:0] a, input logic we,
                                          input t_ldop ld, input t_sop st);
        logic m;
        m = 1'b0;
        if (we) begin
            case (st)
                ST_SH:   m = a[0];
                ST_SW:   m = |a;
                default: m = 1'b0;
            endcase
        end else begin
            case (ld)
                LD_LH, LD_LHU: m = a[0];
                LD_LW:         m = |a;
                default:       m = 1'b0;
            endcase
        end
        return m;
    endfunction

    assign w_stall         = (r_state == S_REQ) || (r_state == S_RESP);
    assign w_timeout       = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);
    assign w_in_misaligned = f_misaligned(i_exe_calc[1:0], i_cu_memwrite, i_ldop, i_sop);
    assign w_misaligned    = r_memaccess && f_misaligned(r_calc[1:0], r_memwrite, r_ldop, r_sop);

    // Control registers and access FSM; a new instruction is only taken while IDLE.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_regwrite  <= 1'b0;
            r_memwrite  <= 1'b0;
            r_memaccess <= 1'b0;
            r_bus_error <= 1'b0;
            r_ldword    <= '0;
        end else begin
            r_bus_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_regwrite  <= i_en & i_cu_regwrite;
                    r_memwrite  <= i_en & i_cu_memwrite;
                    r_memaccess <= i_en & i_cu_memaccess;
                    if (i_en && i_cu_memaccess && !w_in_misaligned) begin
                        r_state <= S_REQ;
                        r_cnt   <= '0;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (dmem.i_dmem_ready) begin
                        r_state <= r_memwrite ? S_IDLE : S_RESP;
                    end else if (w_timeout) begin
                        r_state     <= S_IDLE;
                        r_bus_error <= 1'b1;
                        r_ldword    <= '0;
                    end
                end
                S_RESP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (dmem.i_dmem_rvalid) begin
                        r_state  <= S_IDLE;
                        r_ldword <= dmem.i_dmem_rdata;
                    end else if (w_timeout) begin
                        r_state     <= S_IDLE;
                        r_bus_error <= 1'b1;
                        r_ldword    <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Data registers: no reset, loaded with a valid instruction whenever the stage is not held.
    always_ff @(posedge i_aclk) begin
        if (!w_stall && i_en) begin
            r_calc     <= i_exe_calc;
            r_wdata    <= i_exe_wdata;
            r_pcplus4  <= i_pcplus4;
            r_rdest    <= i_rdest;
            r_memtoreg <= i_cu_memtoreg;
            r_ldop     <= i_ldop;
            r_sop      <= i_sop;
        end
    end

    // Store lane placement: narrow data replicated across lanes, strobes select the target.
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = r_wdata;
        case (r_sop)
            ST_SB: begin
                w_wstrb = 4'b0001 << r_calc[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            ST_SH: begin
                w_wstrb = 4'b0011 << {r_calc[1], 1'b0};
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
    end

    // Load extraction from the latched response word, selected by the low address bits.
    always_comb begin
        w_byte = r_ldword[7:0];
        case (r_calc[1:0])
            2'd1:    w_byte = r_ldword[15:8];
            2'd2:    w_byte = r_ldword[23:16];
            2'd3:    w_byte = r_ldword[31:24];
            default: w_byte = r_ldword[7:0];
        endcase
        w_half = r_calc[1] ? r_ldword[31:16] : r_ldword[15:0];
        case (r_ldop)
            LD_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  o_rdata = {24'd0, w_byte};
            LD_LH:   o_rdata = {{16{w_half[15]}}, w_half};
            LD_LHU:  o_rdata = {16'd0, w_half};
            default: o_rdata = r_ldword;
        endcase
    end

    assign o_stall           = w_stall;
    assign o_state           = r_state;
    assign o_ma_op           = r_calc;
    assign o_rdest           = r_rdest;
    assign o_cu_memtoreg     = r_memtoreg;
    assign o_pcplus4         = r_pcplus4;
    assign o_misaligned      = w_misaligned;
    assign o_bus_error       = r_bus_error;
    assign o_cu_regwrite     = r_regwrite & !w_stall & !w_misaligned & !r_bus_error;

    assign dmem.o_dmem_valid = (r_state == S_REQ);
    assign dmem.o_dmem_addr  = {r_calc[DATA_SIZE-1:2], 2'b00};
    assign dmem.o_dmem_we    = (r_state == S_REQ) && r_memwrite;
    assign dmem.o_dmem_wstrb = ((r_state == S_REQ) && r_memwrite) ? w_wstrb : 4'b0000;
    assign dmem.o_dmem_wdata = w_wdata;
endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: stores, loads, lane alignment, misalignment,
// timeout abort, reset during an access, bubbles and stall-held back-to-back issue.
module tb_memory_access_unit;
    import memory_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_en = 1'b0;
    logic [31:0] i_exe_calc = '0, i_exe_wdata = '0, i_pcplus4 = '0;
    logic        i_cu_regwrite = 1'b0, i_cu_memwrite = 1'b0, i_cu_memaccess = 1'b0;
    logic [1:0]  i_cu_memtoreg = '0;
    t_ldop       i_ldop = LD_LW;
    t_sop        i_sop = ST_SW;
    logic [4:0]  i_rdest = '0;
    logic        o_stall, o_cu_regwrite, o_misaligned, o_bus_error;
    logic [31:0] o_ma_op, o_rdata, o_pcplus4;
    logic [4:0]  o_rdest;
    logic [1:0]  o_cu_memtoreg, o_state;

    int total = 0;
    int bad = 0;

    memory_access_unit_if #(.DATA_SIZE(32)) bus ();

    memory_access_unit #(.DATA_SIZE(32), .TIMEOUT_CYCLES(8)) dut (
        .i_aclk(clk), .i_areset_n(rst_n), .i_en(i_en),
        .i_exe_calc(i_exe_calc), .i_exe_wdata(i_exe_wdata),
        .i_cu_regwrite(i_cu_regwrite), .i_cu_memwrite(i_cu_memwrite),
        .i_cu_memaccess(i_cu_memaccess), .i_cu_memtoreg(i_cu_memtoreg),
        .i_ldop(i_ldop), .i_sop(i_sop), .i_rdest(i_rdest), .i_pcplus4(i_pcplus4),
        .o_stall(o_stall), .o_ma_op(o_ma_op), .o_rdata(o_rdata), .o_rdest(o_rdest),
        .o_cu_memtoreg(o_cu_memtoreg), .o_pcplus4(o_pcplus4),
        .o_cu_regwrite(o_cu_regwrite), .o_misaligned(o_misaligned),
        .o_bus_error(o_bus_error), .o_state(o_state), .dmem(bus.master)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver: present one instruction (called at posedge+1 while the stage is idle)
    task automatic drive(input logic en, input logic [31:0] calc, input logic [31:0] wd,
                         input logic rw, input logic mw, input logic ma,
                         input t_ldop ld, input t_sop st, input logic [4:0] rd);
        i_en = en; i_exe_calc = calc; i_exe_wdata = wd;
        i_cu_regwrite = rw; i_cu_memwrite = mw; i_cu_memaccess = ma;
        i_ldop = ld; i_sop = st; i_rdest = rd;
        i_cu_memtoreg = 2'b01; i_pcplus4 = 32'h0000_1004;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h exp=0", o_stall); end
        total++; if (bus.o_dmem_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", bus.o_dmem_valid); end
        total++; if (bus.o_dmem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0h exp=0", bus.o_dmem_we); end
        total++; if (bus.o_dmem_wstrb !== 4'h0) begin bad++; $display("FAIL reset_wstrb got=%0h exp=0", bus.o_dmem_wstrb); end
        total++; if (o_cu_regwrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%0h exp=0", o_cu_regwrite); end
        total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned got=%0h exp=0", o_misaligned); end
        total++; if (o_bus_error !== 1'b0) begin bad++; $display("FAIL reset_bus_error got=%0h exp=0", o_bus_error); end
        total++; if (o_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0h exp=0", o_state); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sw();
        bus.i_dmem_ready = 1'b1;
        drive(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, LD_LW, ST_SW, 5'd0);
        @(posedge clk); #1;
        i_en = 1'b0;
        total++; if (bus.o_dmem_valid !== 1'b1) begin bad++; $display("FAIL sw_valid got=%0h exp=1", bus.o_dmem_valid); end
        total++; if (bus.o_dmem_we !== 1'b1) begin bad++; $display("FAIL sw_we got=%0h exp=1", bus.o_dmem_we); end
        total++; if (bus.o_dmem_wstrb !== 4'b1111) begin bad++; $display("FAIL sw_wstrb got=%0h exp=f", bus.o_dmem_wstrb); end
        total++; if (bus.o_dmem_addr !== 32'h100) begin bad++; $display("FAIL sw_addr got=%0h exp=100", bus.o_dmem_addr); end
        total++; if (bus.o_dmem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_wdata got=%0h exp=deadbeef", bus.o_dmem_wdata); end
        total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL sw_stall1 got=%0h exp=1", o_stall); end
        @(posedge clk); #1;
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL sw_stall2 got=%0h exp=0", o_stall); end
        total++; if (bus.o_dmem_valid !== 1'b0) begin bad++; $display("FAIL sw_valid2 got=%0h exp=0", bus.o_dmem_valid); end
        bus.i_dmem_ready = 1'b0;
    endtask

    // one wait before ready, response two cycles after acceptance; stray rvalid in REQ ignored
    task automatic test_load(input t_ldop ld, input logic [31:0] addr, input logic [31:0] exp_data);
        int nst;
        logic [31:0] exp_addr;
        nst = 0;
        exp_addr = {addr[31:2], 2'b00};
        bus.i_dmem_ready = 1'b0; bus.i_dmem_rvalid = 1'b1; bus.i_dmem_rdata = 32'hFFFF_FFFF;
        drive(1'b1, addr, 32'h0, 1'b1, 1'b0, 1'b1, ld, ST_SW, 5'd7);
        @(posedge clk); #1;
        i_en = 1'b0; bus.i_dmem_rvalid = 1'b0;
        if (o_stall) nst++;
        total++; if (bus.o_dmem_valid !== 1'b1) begin bad++; $display("FAIL ld%0d_valid got=%0h exp=1", ld, bus.o_dmem_valid); end
        total++; if (bus.o_dmem_addr !== exp_addr) begin bad++; $display("FAIL ld%0d_addr got=%0h exp=%0h", ld, bus.o_dmem_addr, exp_addr); end
        total++; if (bus.o_dmem_we !== 1'b0) begin bad++; $display("FAIL ld%0d_we got=%0h exp=0", ld, bus.o_dmem_we); end
        @(posedge clk); #1;
        if (o_stall) nst++;
        bus.i_dmem_ready = 1'b1;
        @(posedge clk); #1;
        if (o_stall) nst++;
        bus.i_dmem_ready = 1'b0;
        total++; if (bus.o_dmem_valid !== 1'b0) begin bad++; $display("FAIL ld%0d_resp_valid got=%0h exp=0", ld, bus.o_dmem_valid); end
        @(posedge clk); #1;
        if (o_stall) nst++;
        bus.i_dmem_rvalid = 1'b1; bus.i_dmem_rdata = 32'h80FF_0000;
        @(posedge clk); #1;
        bus.i_dmem_rvalid = 1'b0;
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL ld%0d_stall_end got=%0h exp=0", ld, o_stall); end
        total++; if (nst !== 4) begin bad++; $display("FAIL ld%0d_stall_cycles got=%0d exp=4", ld, nst); end
        total++; if (o_rdata !== exp_data) begin bad++; $display("FAIL ld%0d_rdata got=%0h exp=%0h", ld, o_rdata, exp_data); end
        total++; if (o_cu_regwrite !== 1'b1) begin bad++; $display("FAIL ld%0d_regwrite got=%0h exp=1", ld, o_cu_regwrite); end
        total++; if (o_rdest !== 5'd7) begin bad++; $display("FAIL ld%0d_rdest got=%0h exp=7", ld, o_rdest); end
    endtask

    task automatic test_store(input t_sop st, input logic [31:0] addr, input logic [31:0] d,
                              input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        bus.i_dmem_ready = 1'b1;
        drive(1'b1, addr, d, 1'b0, 1'b1, 1'b1, LD_LW, st, 5'd0);
        @(posedge clk); #1;
        i_en = 1'b0;
        total++; if (bus.o_dmem_wstrb !== exp_strb) begin bad++; $display("FAIL st%0d_wstrb got=%0h exp=%0h", st, bus.o_dmem_wstrb, exp_strb); end
        total++; if (bus.o_dmem_wdata !== exp_wdata) begin bad++; $display("FAIL st%0d_wdata got=%0h exp=%0h", st, bus.o_dmem_wdata, exp_wdata); end
        total++; if (bus.o_dmem_valid !== 1'b1) begin bad++; $display("FAIL st%0d_valid got=%0h exp=1", st, bus.o_dmem_valid); end
        @(posedge clk); #1;
        total++; if (bus.o_dmem_valid !== 1'b0) begin bad++; $display("FAIL st%0d_done got=%0h exp=0", st, bus.o_dmem_valid); end
        bus.i_dmem_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        bus.i_dmem_ready = 1'b1;
        drive(1'b1, 32'h0000_0102, 32'h0, 1'b1, 1'b0, 1'b1, LD_LW, ST_SW, 5'd3);
        @(posedge clk); #1;
        i_en = 1'b0;
        total++; if (o_misaligned !== 1'b1) begin bad++; $display("FAIL mis_lw_flag got=%0h exp=1", o_misaligned); end
        total++; if (bus.o_dmem_valid !== 1'b0) begin bad++; $display("FAIL mis_lw_valid got=%0h exp=0", bus.o_dmem_valid); end
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL mis_lw_stall got=%0h exp=0", o_stall); end
        total++; if (o_cu_regwrite !== 1'b0) begin bad++; $display("FAIL mis_lw_regwrite got=%0h exp=0", o_cu_regwrite); end
        @(posedge clk); #1;
        total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL mis_lw_clear got=%0h exp=0", o_misaligned); end
        total++; if (bus.o_dmem_valid !== 1'b0) begin bad++; $display("FAIL mis_lw_valid2 got=%0h exp=0", bus.o_dmem_valid); end
        drive(1'b1, 32'h0000_0101, 32'h1234, 1'b0, 1'b1, 1'b1, LD_LW, ST_SH, 5'd0);
        @(posedge clk); #1;
        i_en = 1'b0;
        total++; if (o_misaligned !== 1'b1) begin bad++; $display("FAIL mis_sh_flag got=%0h exp=1", o_misaligned); end
        total++; if (bus.o_dmem_valid !== 1'b0) begin bad++; $display("FAIL mis_sh_valid got=%0h exp=0", bus.o_dmem_valid); end
        @(posedge clk); #1;
        bus.i_dmem_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int nst;
        nst = 0;
        bus.i_dmem_ready = 1'b0; bus.i_dmem_rvalid = 1'b0;
        drive(1'b1, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 1'b1, LD_LW, ST_SW, 5'd4);
        @(posedge clk); #1;
        i_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!o_stall) break;
            nst++;
            @(posedge clk); #1;
        end
        total++; if (nst !== 8) begin bad++; $display("FAIL to_stall_cycles got=%0d exp=8", nst); end
        total++; if (o_bus_error !== 1'b1) begin bad++; $display("FAIL to_bus_error got=%0h exp=1", o_bus_error); end
        total++; if (o_cu_regwrite !== 1'b0) begin bad++; $display("FAIL to_regwrite got=%0h exp=0", o_cu_regwrite); end
        total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata got=%0h exp=0", o_rdata); end
        @(posedge clk); #1;
        total++; if (o_bus_error !== 1'b0) begin bad++; $display("FAIL to_bus_error_clear got=%0h exp=0", o_bus_error); end
    endtask

    task automatic test_reset_mid();
        bus.i_dmem_ready = 1'b1;
        drive(1'b1, 32'h0000_0300, 32'h0, 1'b1, 1'b0, 1'b1, LD_LW, ST_SW, 5'd6);
        @(posedge clk); #1;
        i_en = 1'b0;
        @(posedge clk); #1;
        bus.i_dmem_ready = 1'b0;
        total++; if (o_state !== 2'd2) begin bad++; $display("FAIL rm_in_resp got=%0h exp=2", o_state); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (bus.o_dmem_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%0h exp=0", bus.o_dmem_valid); end
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL rm_stall got=%0h exp=0", o_stall); end
        bus.i_dmem_rvalid = 1'b1; bus.i_dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.i_dmem_rvalid = 1'b0;
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL rm_late_stall got=%0h exp=0", o_stall); end
        total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL rm_late_rdata got=%0h exp=0", o_rdata); end
        total++; if (o_cu_regwrite !== 1'b0) begin bad++; $display("FAIL rm_regwrite got=%0h exp=0", o_cu_regwrite); end
    endtask

    task automatic test_bubble();
        bus.i_dmem_ready = 1'b1;
        drive(1'b0, 32'h0000_0400, 32'h0, 1'b1, 1'b0, 1'b1, LD_LW, ST_SW, 5'd2);
        @(posedge clk); #1;
        total++; if (o_cu_regwrite !== 1'b0) begin bad++; $display("FAIL bub_regwrite got=%0h exp=0", o_cu_regwrite); end
        total++; if (bus.o_dmem_valid !== 1'b0) begin bad++; $display("FAIL bub_valid got=%0h exp=0", bus.o_dmem_valid); end
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL bub_stall got=%0h exp=0", o_stall); end
        bus.i_dmem_ready = 1'b0;
    endtask

    task automatic test_alu_pass();
        drive(1'b1, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 1'b0, LD_LW, ST_SW, 5'd9);
        i_cu_memtoreg = 2'b10; i_pcplus4 = 32'h0000_2004;
        @(posedge clk); #1;
        i_en = 1'b0;
        total++; if (o_cu_regwrite !== 1'b1) begin bad++; $display("FAIL alu_regwrite got=%0h exp=1", o_cu_regwrite); end
        total++; if (o_ma_op !== 32'h1234_5678) begin bad++; $display("FAIL alu_ma_op got=%0h exp=12345678", o_ma_op); end
        total++; if (o_rdest !== 5'd9) begin bad++; $display("FAIL alu_rdest got=%0h exp=9", o_rdest); end
        total++; if (o_cu_memtoreg !== 2'b10) begin bad++; $display("FAIL alu_memtoreg got=%0h exp=2", o_cu_memtoreg); end
        total++; if (o_pcplus4 !== 32'h0000_2004) begin bad++; $display("FAIL alu_pcplus4 got=%0h exp=2004", o_pcplus4); end
        @(posedge clk); #1;
        total++; if (o_cu_regwrite !== 1'b0) begin bad++; $display("FAIL alu_bubble_regwrite got=%0h exp=0", o_cu_regwrite); end
    endtask

    // load presented while a store is stalling must wait and then issue correctly
    task automatic test_back_to_back();
        bus.i_dmem_ready = 1'b1;
        drive(1'b1, 32'h0000_0500, 32'h5555_AAAA, 1'b0, 1'b1, 1'b1, LD_LW, ST_SW, 5'd0);
        @(posedge clk); #1;
        drive(1'b1, 32'h0000_0504, 32'h0, 1'b1, 1'b0, 1'b1, LD_LW, ST_SW, 5'd11);
        @(posedge clk); #1;
        total++; if (o_ma_op !== 32'h0000_0500) begin bad++; $display("FAIL b2b_held_op got=%0h exp=500", o_ma_op); end
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL b2b_gap_stall got=%0h exp=0", o_stall); end
        @(posedge clk); #1;
        i_en = 1'b0;
        total++; if (bus.o_dmem_addr !== 32'h0000_0504) begin bad++; $display("FAIL b2b_ld_addr got=%0h exp=504", bus.o_dmem_addr); end
        total++; if (bus.o_dmem_we !== 1'b0) begin bad++; $display("FAIL b2b_ld_we got=%0h exp=0", bus.o_dmem_we); end
        @(posedge clk); #1;
        bus.i_dmem_ready = 1'b0; bus.i_dmem_rvalid = 1'b1; bus.i_dmem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.i_dmem_rvalid = 1'b0;
        total++; if (o_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL b2b_rdata got=%0h exp=cafef00d", o_rdata); end
        total++; if (o_cu_regwrite !== 1'b1) begin bad++; $display("FAIL b2b_regwrite got=%0h exp=1", o_cu_regwrite); end
        total++; if (o_rdest !== 5'd11) begin bad++; $display("FAIL b2b_rdest got=%0h exp=11", o_rdest); end
    endtask

    initial begin
        bus.i_dmem_ready = 1'b0; bus.i_dmem_rvalid = 1'b0; bus.i_dmem_rdata = '0;
        test_reset();
        test_sw();
        test_load(LD_LB,  32'h0000_0103, 32'hFFFF_FF80);
        test_load(LD_LBU, 32'h0000_0103, 32'h0000_0080);
        test_load(LD_LH,  32'h0000_0102, 32'hFFFF_80FF);
        test_load(LD_LHU, 32'h0000_0102, 32'h0000_80FF);
        test_load(LD_LW,  32'h0000_0100, 32'h80FF_0000);
        test_store(ST_SB, 32'h0000_0101, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
        test_store(ST_SH, 32'h0000_0102, 32'h0000_1234, 4'b1100, 32'h1234_1234);
        test_store(ST_SB, 32'h0000_0103, 32'h0000_0012, 4'b1000, 32'h1212_1212);
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_bubble();
        test_alu_pass();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
